muldiv_sequencer: RTL
=====================

# muldiv_sequencer

Controller that sequences the shared multi-cycle multiply/divide unit (`multiclockalu`) for the execute stage. It accepts one M-extension operation at a time over a valid/ready handshake and drives the unit's start pulse. It holds the unit's operands and opcode stable for the whole computation and returns the result over a second valid/ready handshake. It also stalls the pipeline while busy and absorbs flushes without corrupting the in-flight computation.

## Interface
- Parameters: none.
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: execute stage presents an operation.
- `req_ready` out 1: sequencer accepts; high only in IDLE.
- `req_alucode` in 6: `ALU_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU`.
- `req_op1`, `req_op2` in 32: operands.
- `req_rd` in 5: destination tag, returned with the result.
- `flush` in 1: discard any accepted and not-yet-returned operation.
- `alu_start` out 1: one-cycle start pulse to the unit's start input.
- `alu_alucode` out 6, `alu_op1` out 32, `alu_op2` out 32: registered; stable from ISSUE until the unit's done is captured.
- `alu_result` in 32, `alu_done` in 1: from the unit.
- `resp_valid` out 1, `resp_ready` in 1: result handshake.
- `resp_result` out 32, `resp_rd` out 5: result and tag; stable while `resp_valid` is high.
- `busy` out 1: high in any state except IDLE; drives the pipeline stall.

## Operation
- States:
  - IDLE: `req_ready`=1. On `req_valid`, latch the operands, code and tag. Next state is ISSUE, or RESP on a cache hit or a non-M code.
  - ISSUE: `alu_start`=1 for exactly one cycle. Next state is WAIT.
  - WAIT: hold the `alu_*` outputs. When `alu_done`=1, capture `alu_result` and go to RESP.
  - RESP: `resp_valid`=1. When `resp_ready`=1, go to IDLE.
  - DRAIN: the flush arrived while the unit was running. Wait for `alu_done`, discard the result, then go to IDLE.
- The unit reads its opcode combinationally on every cycle, so `alu_alucode`, `alu_op1` and `alu_op2` change only on acceptance in IDLE.
- `alu_done` is sampled only in WAIT and DRAIN. Its stale value during ISSUE is ignored.
- A non-M `req_alucode` is accepted but the unit is not started. The response is 32'h0, and the cache is not updated.
- Flush behaviour by state:
  - Flush in ISSUE or WAIT goes to DRAIN.
  - Flush in RESP drops `resp_valid` and goes to IDLE.
  - Flush in IDLE blocks acceptance for that cycle.
  - Flush in DRAIN has no further effect.
- `req_valid` and `flush` in the same cycle: flush wins, and the request is not accepted.
- Reset mid-operation: all state returns to IDLE immediately. The unit's current computation completes unobserved, and the next ISSUE restarts it.
- Reset values: `req_ready`=1, `busy`=0, and all other outputs 0.

## Timing
- Request accepted at cycle T. `alu_start` is high at T+1, and the first WAIT cycle is T+2.
- Zero-divide and DIV overflow: the unit raises done in the ISSUE cycle, so `resp_valid` rises at T+3.
- General latency: `resp_valid` at T+2+k, where k is the number of WAIT cycles until `alu_done`. Typical k is about 18 for divide and 6–8 for multiply.
- Cache hit or non-M code: `resp_valid` at T+1.
- Back-to-back requests: the next `req_ready` comes the cycle after the response handshake, so there is one idle cycle minimum between operations.

## Configuration
- `MULDIV_RESULT_CACHE_EN` defined:
  - One-entry cache with tag {alucode, op1, op2} and a 32-bit value.
  - Updated on each non-flushed WAIT completion. Invalidated only by reset.
  - A request matching a valid entry skips ISSUE/WAIT and responds at T+1.
- `MULDIV_RESULT_CACHE_EN` undefined: no cache storage, and every M request goes through ISSUE.

## Structure
- The `ALU_*` opcode codes come from the shared defines. Add an `is_muldiv` helper macro to the same file.
- The state encoding is a localparam set local to this module.
- The cache is a natural sub-module, `muldiv_result_cache`: lookup port, update port and valid flag. It is instantiated only under the macro.
- `multiclockalu` is instantiated by the parent, not inside this block.

## Test plan
- DIVU with op1=100, op2=7 -> `alu_start` at T+1, response 14 with the correct rd, and `alu_op*` stable until done.
- DIV with op2=0 -> response 32'hffffffff at T+3. DIV with op1=32'h80000000, op2=32'hffffffff -> 32'h80000000 at T+3.
- MULH with op1=32'hffffffff, op2=2 -> 32'hffffffff. Hold `resp_ready`=0 for 5 cycles and check that the output stays stable and no new request is accepted.
- Flush 3 cycles into a DIV -> DRAIN, no response, `busy` stays high until `alu_done`. The next REMU with op1=10, op2=3 returns 1.
- With the cache enabled, repeat MUL with op1=6, op2=7 -> the second request returns 42 at T+1 with no `alu_start`. With the cache disabled, the full latency applies.
- Assert `rst` low during WAIT -> outputs at reset values on the same edge. The next MULHU with op1=op2=32'h80000000 returns 32'h40000000.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer_pkg
//  Description : Shared M-extension opcode codes, cache tag type and the
//                IS_MULDIV helper macro (MULDIV_RESULT_CACHE_EN selects cache).
//  Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

   localparam logic [5:0] ALU_ADD    = 6'd0;
   localparam logic [5:0] ALU_MUL    = 6'd24;
   localparam logic [5:0] ALU_MULH   = 6'd25;
   localparam logic [5:0] ALU_MULHSU = 6'd26;
   localparam logic [5:0] ALU_MULHU  = 6'd27;
   localparam logic [5:0] ALU_DIV    = 6'd28;
   localparam logic [5:0] ALU_DIVU   = 6'd29;
   localparam logic [5:0] ALU_REM    = 6'd30;
   localparam logic [5:0] ALU_REMU   = 6'd31;

   typedef struct packed {
      logic [5:0]  alucode;
      logic [31:0] op1;
      logic [31:0] op2;
   } muldiv_tag_t;

endpackage

// The M codes occupy one contiguous range, so a range test is sufficient.
`ifndef IS_MULDIV
`define IS_MULDIV(code) (((code) >= muldiv_sequencer_pkg::ALU_MUL) && ((code) <= muldiv_sequencer_pkg::ALU_REMU))
`endif

`default_nettype wire

// File: rtl/muldiv_result_cache.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_result_cache
//  Description : One-entry result cache keyed on {alucode, op1, op2}; built
//                only when MULDIV_RESULT_CACHE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_result_cache
   import muldiv_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  lookup_alucode,
   input  logic [31:0] lookup_op1,
   input  logic [31:0] lookup_op2,
   output logic        lookup_match,
   output logic [31:0] lookup_value,
   input  logic        update_en,
   input  logic [5:0]  update_alucode,
   input  logic [31:0] update_op1,
   input  logic [31:0] update_op2,
   input  logic [31:0] update_value,
   output logic        valid
);

   muldiv_tag_t r_tag;
   muldiv_tag_t w_lookup_tag;
   logic [31:0] r_value;
   logic        r_valid;

   assign w_lookup_tag = {lookup_alucode, lookup_op1, lookup_op2};
   assign lookup_match = (w_lookup_tag == r_tag);
   assign lookup_value = r_value;
   assign valid        = r_valid;

   // Only reset clears the valid flag; later updates simply overwrite.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_valid <= 1'b0;
         r_tag   <= '0;
         r_value <= '0;
      end else if (update_en) begin
         r_valid <= 1'b1;
         r_tag   <= {update_alucode, update_op1, update_op2};
         r_value <= update_value;
      end
   end

endmodule

`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : muldiv_sequencer
//  Description : Sequences the shared multi-cycle mul/div unit for execute;
//                MULDIV_RESULT_CACHE_EN adds a one-entry result cache.
//  Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
   import muldiv_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [5:0]  req_alucode,
   input  logic [31:0] req_op1,
   input  logic [31:0] req_op2,
   input  logic [4:0]  req_rd,
   input  logic        flush,
   output logic        alu_start,
   output logic [5:0]  alu_alucode,
   output logic [31:0] alu_op1,
   output logic [31:0] alu_op2,
   input  logic [31:0] alu_result,
   input  logic        alu_done,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_result,
   output logic [4:0]  resp_rd,
   output logic        busy
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_ISSUE = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_RESP  = 3'd3;
   localparam logic [2:0] S_DRAIN = 3'd4;

   logic [2:0]  r_state;
   logic [2:0]  w_state_next;
   logic        w_accept;
   logic        w_is_m;
   logic        w_hit;
   logic [31:0] w_hit_value;
   logic        w_wait_done;

   assign w_accept    = (r_state == S_IDLE) && req_valid && !flush;
   assign w_is_m      = `IS_MULDIV(req_alucode);
   assign w_wait_done = (r_state == S_WAIT) && alu_done && !flush;

`ifdef MULDIV_RESULT_CACHE_EN
   logic w_cache_match;
   logic w_cache_valid;

   muldiv_result_cache u_cache (
      .clk            (clk),
      .rst            (rst),
      .lookup_alucode (req_alucode),
      .lookup_op1     (req_op1),
      .lookup_op2     (req_op2),
      .lookup_match   (w_cache_match),
      .lookup_value   (w_hit_value),
      .update_en      (w_wait_done),
      .update_alucode (alu_alucode),
      .update_op1     (alu_op1),
      .update_op2     (alu_op2),
      .update_value   (alu_result),
      .valid          (w_cache_valid)
   );

   assign w_hit = w_cache_valid && w_cache_match;
`else
   assign w_hit       = 1'b0;
   assign w_hit_value = '0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      req_ready    = 1'b0;
      alu_start    = 1'b0;
      resp_valid   = 1'b0;
      busy         = 1'b1;
      case (r_state)
         S_IDLE: begin
            req_ready = 1'b1;
            busy      = 1'b0;
            if (w_accept) w_state_next = (!w_is_m || w_hit) ? S_RESP : S_ISSUE;
         end
         S_ISSUE: begin
            alu_start    = 1'b1;
            w_state_next = flush ? S_DRAIN : S_WAIT;
         end
         S_WAIT: begin
            // A flush coinciding with done has nothing left to drain.
            if (flush)         w_state_next = alu_done ? S_IDLE : S_DRAIN;
            else if (alu_done) w_state_next = S_RESP;
         end
         S_RESP: begin
            resp_valid = 1'b1;
            if (flush || resp_ready) w_state_next = S_IDLE;
         end
         S_DRAIN: begin
            if (alu_done) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // The unit decodes alu_* combinationally, so they move only on acceptance.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         alu_alucode <= '0;
         alu_op1     <= '0;
         alu_op2     <= '0;
         resp_result <= '0;
         resp_rd     <= '0;
      end else begin
         if (w_accept) begin
            alu_alucode <= req_alucode;
            alu_op1     <= req_op1;
            alu_op2     <= req_op2;
            resp_rd     <= req_rd;
            if (!w_is_m)    resp_result <= '0;
            else if (w_hit) resp_result <= w_hit_value;
         end
         if (w_wait_done) resp_result <= alu_result;
      end
   end

endmodule

`default_nettype wire
